// File: rtl/sync_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_arb_pkg
// Description : Shared types and helpers for sync_channel_arbiter.
//               - arb_state_e   : arbiter FSM state encoding
//               - ONEHOT_MAX_W  : widest one-hot vector idx_to_onehot returns
//               - cnt_width()   : hold/gap counter width
//               - id_width()    : requester index width (at least 1 bit)
//               - idx_to_onehot : index to one-hot conversion
// Revision    : 1.0 - initial release
// ============================================================================
package sync_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_HOLD = 2'd1,
        ARB_GAP  = 2'd2
    } arb_state_e;

    localparam int ONEHOT_MAX_W = 32;

    // Counter must hold max(HOLD_CYCLES, GAP_CYCLES) - 1; sizing for max+1
    // keeps it at least one bit wide when both are small.
    function automatic int cnt_width(input int hold, input int gap);
        int m;
        m = (hold > gap) ? hold : gap;
        return $clog2(m + 1);
    endfunction

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [ONEHOT_MAX_W-1:0] idx_to_onehot(input int unsigned idx);
        logic [ONEHOT_MAX_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_select.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_select
// Description : Combinational requester selector.
//               Default: round robin, first asserted req searching upward
//               from ptr+1 and wrapping modulo NUM_REQ.
//               SYNC_ARB_FIXED_PRIO_EN defined: lowest asserted index wins,
//               ptr is ignored.
// Ports       : req [NUM_REQ] in  - request levels
//               ptr [ID_W]    in  - index of the last granted requester
//               sel [ID_W]    out - selected requester (valid when any=1)
//               any           out - at least one request asserted
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_select
    import sync_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    sel,
    output logic               any
);

    logic [ID_W-1:0] w_idx;

`ifdef SYNC_ARB_FIXED_PRIO_EN
    logic w_unused_ptr;
    assign w_unused_ptr = ^ptr;

    // Scanning from the top down lets the lowest asserted index overwrite
    // any higher one.
    always_comb begin
        sel   = '0;
        any   = |req;
        w_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_idx = ID_W'(i);
            if (req[w_idx]) begin
                sel = w_idx;
            end
        end
    end
`else
    // Scan offsets from the farthest to the nearest so the closest asserted
    // requester after ptr is the one left in sel.
    always_comb begin
        sel   = '0;
        any   = |req;
        w_idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_idx = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (req[w_idx]) begin
                sel = w_idx;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/sync_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sync_channel_arbiter
// Description : Shares one fast-to-slow data synchronizer between NUM_REQ
//               requesters. A winner's word is latched onto out_data and held
//               with out_valid high for HOLD_CYCLES, followed by GAP_CYCLES
//               with out_valid low, then at least one IDLE cycle.
//               out_data/out_id only change at a selection edge or reset.
//               Build option: SYNC_ARB_FIXED_PRIO_EN selects fixed priority
//               (lowest index wins) instead of round robin.
// Ports       : clk        in  fast-domain clock
//               reset      in  synchronous active-high reset
//               req        in  per-requester request level
//               req_data   in  requester i word at [i*DATA_W +: DATA_W]
//               grant      out one-hot single-cycle accept pulse
//               out_data   out word driven to the synchronizer
//               out_id     out owner index of out_data
//               out_valid  out high during the hold window
//               busy       out high whenever not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module sync_channel_arbiter
    import sync_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 24,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         grant,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(NUM_REQ)-1:0] out_id,
    output logic                       out_valid,
    output logic                       busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);

    localparam logic [CNT_W-1:0] c_hold_load = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_gap_load  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    // Pointer starts at the last requester so requester 0 wins first.
    localparam logic [ID_W-1:0]  c_ptr_rst   = ID_W'(NUM_REQ - 1);

    arb_state_e          r_state, w_state_nx;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
    logic [ID_W-1:0]     r_ptr, w_ptr_nx;
    logic [DATA_W-1:0]   r_out_data, w_data_nx;
    logic [ID_W-1:0]     r_out_id, w_id_nx;
    logic                r_out_valid, w_valid_nx;
    logic [NUM_REQ-1:0]  r_grant, w_grant_nx;

    logic [ID_W-1:0]     w_sel;
    logic                w_any;
    logic [DATA_W-1:0]   w_words [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_words[g] = req_data[g*DATA_W +: DATA_W];
    end

    rr_priority_select #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_sel (
        .req (req),
        .ptr (r_ptr),
        .sel (w_sel),
        .any (w_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ARB_IDLE;
            r_cnt       <= '0;
            r_ptr       <= c_ptr_rst;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_out_valid <= 1'b0;
            r_grant     <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_ptr       <= w_ptr_nx;
            r_out_data  <= w_data_nx;
            r_out_id    <= w_id_nx;
            r_out_valid <= w_valid_nx;
            r_grant     <= w_grant_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_ptr_nx   = r_ptr;
        w_data_nx  = r_out_data;
        w_id_nx    = r_out_id;
        w_valid_nx = r_out_valid;
        w_grant_nx = '0;

        unique case (r_state)
            ARB_IDLE: begin
                if (w_any) begin
                    w_data_nx  = w_words[w_sel];
                    w_id_nx    = w_sel;
                    w_grant_nx = NUM_REQ'(idx_to_onehot(32'(w_sel)));
                    w_valid_nx = 1'b1;
                    w_cnt_nx   = c_hold_load;
                    w_ptr_nx   = w_sel;
                    w_state_nx = ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - 1'b1;
                end else begin
                    w_valid_nx = 1'b0;
                    if (GAP_CYCLES > 0) begin
                        w_cnt_nx   = c_gap_load;
                        w_state_nx = ARB_GAP;
                    end else begin
                        w_state_nx = ARB_IDLE;
                    end
                end
            end
            ARB_GAP: begin
                if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - 1'b1;
                end else begin
                    w_state_nx = ARB_IDLE;
                end
            end
            default: begin
                w_state_nx = ARB_IDLE;
                w_valid_nx = 1'b0;
            end
        endcase
    end

    assign grant     = r_grant;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != ARB_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sync_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_channel_arbiter
// Description : Self-checking bench for sync_channel_arbiter. One instance
//               uses the default parameters, a second uses GAP_CYCLES=0.
//               Expected values depend on SYNC_ARB_FIXED_PRIO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_channel_arbiter;

    localparam int NR = 4;
    localparam int DW = 24;

`ifdef SYNC_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic              clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     grant;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_id;
    logic              out_valid;
    logic              busy;

    logic              reset0;
    logic [NR-1:0]     req0;
    logic [NR*DW-1:0]  req_data0;
    logic [NR-1:0]     grant0;
    logic [DW-1:0]     out_data0;
    logic [1:0]        out_id0;
    logic              out_valid0;
    logic              busy0;

    sync_channel_arbiter #(
        .NUM_REQ(NR), .DATA_W(DW), .HOLD_CYCLES(8), .GAP_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .grant(grant), .out_data(out_data), .out_id(out_id),
        .out_valid(out_valid), .busy(busy)
    );

    sync_channel_arbiter #(
        .NUM_REQ(NR), .DATA_W(DW), .HOLD_CYCLES(8), .GAP_CYCLES(0)
    ) dut0 (
        .clk(clk), .reset(reset0), .req(req0), .req_data(req_data0),
        .grant(grant0), .out_data(out_data0), .out_id(out_id0),
        .out_valid(out_valid0), .busy(busy0)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] lane_word(input logic [DW-1:0] base, input int i);
        logic [31:0] m;
        m = 32'h111111 * i;
        return base ^ m[DW-1:0];
    endfunction

    function automatic int oh2idx(input logic [NR-1:0] oh);
        int r;
        r = -1;
        for (int i = 0; i < NR; i++) if (oh[i]) r = i;
        return r;
    endfunction

    task automatic set_words(input logic [DW-1:0] base);
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = lane_word(base, i);
    endtask

    typedef struct {
        bit            rst_first;
        logic [NR-1:0] rq;
        logic [DW-1:0] word;
        int            exp_rr;
        int            exp_fp;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_id, hi, lo, got, prev, rep, id, c0, c2;
        int gcnt [NR];
        logic [DW-1:0] exp_word;

        tbl[0] = '{1'b1, 4'b0010, 24'hABCDEF, 1, 1};
        tbl[1] = '{1'b0, 4'b0011, 24'h010203, 0, 0};
        tbl[2] = '{1'b0, 4'b0011, 24'h5A5A5A, 1, 0};
        tbl[3] = '{1'b0, 4'b1001, 24'hC0FFEE, 3, 0};
        tbl[4] = '{1'b0, 4'b1001, 24'h00FF00, 0, 0};
        tbl[5] = '{1'b0, 4'b1000, 24'h123456, 3, 3};
        tbl[6] = '{1'b1, 4'b1111, 24'hFEDCBA, 0, 0};
        tbl[7] = '{1'b0, 4'b0110, 24'h777777, 1, 1};
        tbl[8] = '{1'b0, 4'b0110, 24'h800001, 2, 1};
        tbl[9] = '{1'b0, 4'b0101, 24'h0F0F0F, 0, 0};

        reset = 1'b1; req = '0; req_data = '0;
        reset0 = 1'b1; req0 = '0; req_data0 = '0;

        // ---------------- table-driven single transfers ----------------
        for (int k = 0; k < 10; k++) begin
            if (tbl[k].rst_first) begin
                reset = 1'b1; req = '0;
                @(negedge clk);
                chk("rst_grant", grant, 0);
                chk("rst_valid", out_valid, 0);
                chk("rst_data", out_data, 0);
                chk("rst_id", out_id, 0);
                chk("rst_busy", busy, 0);
                reset = 1'b0;
            end else begin
                for (int t = 0; t < 40 && busy; t++) @(negedge clk);
                chk("idle_before", busy, 0);
            end
            set_words(tbl[k].word);
            req = tbl[k].rq;
            exp_id   = FIXED ? tbl[k].exp_fp : tbl[k].exp_rr;
            exp_word = lane_word(tbl[k].word, exp_id);
            @(negedge clk);
            chk("grant", grant, 32'(1 << exp_id));
            chk("out_id", out_id, exp_id);
            chk("out_data", out_data, exp_word);
            chk("valid_rise", out_valid, 1);
            req = '0;
            hi = 1;
            for (int t = 0; t < 30; t++) begin
                @(negedge clk);
                if (t == 0) chk("grant_pulse", grant, 0);
                if (!out_valid) break;
                hi++;
            end
            chk("hold_len", hi, 8);
            lo = 0;
            for (int t = 0; t < 30; t++) begin
                if (!busy) break;
                lo++;
                @(negedge clk);
            end
            chk("gap_len", lo, 4);
            chk("data_kept", out_data, exp_word);
        end

        // ---------------- simultaneous requests, drop after grant ----------------
        reset = 1'b1; req = '0;
        @(negedge clk);
        reset = 1'b0;
        set_words(24'h246801);
        req = 4'b1111;
        got = 0; prev = 0;
        for (int t = 0; t < 100 && got < 4; t++) begin
            @(negedge clk);
            if (grant != '0) begin
                id = oh2idx(grant);
                chk("orderA", id, got);
                if (got > 0) chk("spacingA", cyc - prev, 13);
                prev = cyc;
                req = req & ~grant;
                got++;
            end
        end
        chk("grantsA", got, 4);

        // ---------------- fairness, all continuously requesting ----------------
        req = 4'b1111;
        for (int i = 0; i < NR; i++) gcnt[i] = 0;
        got = 0; prev = -1; rep = 0;
        for (int t = 0; t < 40*13 + 40 && got < 40; t++) begin
            @(negedge clk);
            if (grant != '0) begin
                id = oh2idx(grant);
                if (id == prev) rep++;
                if (id >= 0) gcnt[id]++;
                prev = id;
                got++;
            end
        end
        chk("fair_total", got, 40);
        for (int i = 0; i < NR; i++)
            chk($sformatf("fair_cnt%0d", i), gcnt[i], FIXED ? ((i == 0) ? 40 : 0) : 10);
        chk("fair_repeat", rep, FIXED ? 39 : 0);

        // ---------------- reset during HOLD ----------------
        req = '0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        set_words(24'h3C3C3C);
        req = 4'b0100;
        @(negedge clk);
        chk("rstH_grant", grant, 32'h4);
        @(negedge clk);
        @(negedge clk);
        chk("rstH_valid3", out_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rstH_valid", out_valid, 0);
        chk("rstH_data", out_data, 0);
        chk("rstH_busy", busy, 0);
        chk("rstH_grant0", grant, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rstH_regrant", grant, 32'h4);
        chk("rstH_id", out_id, 2);
        chk("rstH_redata", out_data, lane_word(24'h3C3C3C, 2));

        // ---------------- 0101 held continuously ----------------
        req = '0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req = 4'b0101;
        got = 0; c0 = 0; c2 = 0;
        for (int t = 0; t < 4*13 + 20 && got < 4; t++) begin
            @(negedge clk);
            if (grant != '0) begin
                if (grant[0]) c0++;
                if (grant[2]) c2++;
                got++;
            end
        end
        chk("prio_total", got, 4);
        chk("prio_req0", c0, FIXED ? 4 : 2);
        chk("prio_req2", c2, FIXED ? 0 : 2);
        req = '0;

        // ---------------- GAP_CYCLES = 0 instance ----------------
        for (int i = 0; i < NR; i++) req_data0[i*DW +: DW] = lane_word(24'h0A0B0C, i);
        reset0 = 1'b0;
        req0 = 4'b0011;
        for (int t = 0; t < 5 && !out_valid0; t++) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            chk($sformatf("g0_id%0d", w), out_id0, FIXED ? 0 : w);
            hi = 0;
            for (int t = 0; t < 30 && out_valid0; t++) begin
                hi++;
                @(negedge clk);
            end
            chk($sformatf("g0_hold%0d", w), hi, 8);
            lo = 0;
            for (int t = 0; t < 30 && !out_valid0; t++) begin
                lo++;
                @(negedge clk);
            end
            chk($sformatf("g0_low%0d", w), lo, 1);
        end
        req0 = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
